// File: rtl/sap_bus_pkg.sv
// Shared types and default sizing for the SAP3 bus fabric.
package sap_bus_pkg;

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   localparam int DEF_W        = 16;
   localparam int DEF_NARROW_W = 8;
   localparam int DEF_N_SRC    = 4;
   localparam int DEF_N_DST    = 6;
   localparam int DEF_TIMEOUT  = 15;
   localparam int DEF_CNT_W    = 16;

   // Saturation value for a default-width transfer counter.
   localparam logic [DEF_CNT_W-1:0] CNT_SAT = '1;

endpackage

// File: rtl/sap_bus_src_mux.sv
// Priority bus driver select: lowest enabled index wins, narrow sources are
// zero-extended, and more than one enable flags a multi-driver condition.
module sap_bus_src_mux
   import sap_bus_pkg::*;
#(
   parameter int W        = DEF_W,
   parameter int NARROW_W = DEF_NARROW_W,
   parameter int N_SRC    = DEF_N_SRC
) (
   input  logic [N_SRC-1:0]   oe,
   input  logic [N_SRC*W-1:0] data,
   input  logic [N_SRC-1:0]   wide,
   output logic [W-1:0]       value,
   output logic               multi
);

   // Walk from the highest index down so the lowest enabled source lands last.
   always_comb begin
      value = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (oe[i]) begin
            value = wide[i] ? data[i*W +: W] : W'(data[i*W +: NARROW_W]);
         end
      end
   end

   assign multi = |(oe & (oe - N_SRC'(1)));

endmodule

// File: rtl/sap_bus_fabric.sv
// Shared-bus fabric: priority source mux, per-destination ready handshake with
// wait states, controller stall, sticky error flags and a saturating transfer count.
module sap_bus_fabric
   import sap_bus_pkg::*;
#(
   parameter int W        = DEF_W,
   parameter int NARROW_W = DEF_NARROW_W,
   parameter int N_SRC    = DEF_N_SRC,
   parameter int N_DST    = DEF_N_DST,
   parameter int TIMEOUT  = DEF_TIMEOUT,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_SRC-1:0]   src_oe,
   input  logic [N_SRC*W-1:0] src_data,
   input  logic [N_SRC-1:0]   src_wide,
   input  logic [N_DST-1:0]   dst_we,
   input  logic [N_DST-1:0]   dst_ready,
   input  logic               err_clr,
   output logic [W-1:0]       bus_out,
   output logic [N_DST-1:0]   dst_strb,
   output logic               stall,
   output logic               busy,
   output logic               contention_err,
   output logic               timeout_err,
   output logic [CNT_W-1:0]   xfer_count
);

   localparam int                WC_W    = $clog2(TIMEOUT + 1);
   localparam logic [WC_W-1:0]   WC_LAST = WC_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   state_t             state;
   logic [N_DST-1:0]   pending;
   logic [W-1:0]       bus_hold;
   logic [WC_W-1:0]    wait_cnt;
   logic [W-1:0]       mux_val;
   logic               multi;
   logic [N_DST-1:0]   miss_idle;
   logic [N_DST-1:0]   miss_wait;
   logic               at_limit;
   logic               timed_out;
   logic               cnt_inc;

   sap_bus_src_mux #(
      .W        (W),
      .NARROW_W (NARROW_W),
      .N_SRC    (N_SRC)
   ) u_src_mux (
      .oe    (src_oe),
      .data  (src_data),
      .wide  (src_wide),
      .value (mux_val),
      .multi (multi)
   );

   assign miss_idle = dst_we & ~dst_ready;
   assign miss_wait = pending & ~dst_ready;
   assign at_limit  = (wait_cnt == WC_LAST);
   assign timed_out = (state == WAIT) && (|miss_wait) && at_limit;
   assign cnt_inc   = (state == IDLE) ? (!(|miss_idle) && (|dst_we)) : !(|miss_wait);

   // Outputs are forced quiet whenever reset is asserted, even mid-WAIT.
   always_comb begin
      bus_out  = '0;
      dst_strb = '0;
      stall    = 1'b0;
      busy     = 1'b0;
      if (rst) begin
         if (state == IDLE) begin
            bus_out  = mux_val;
            dst_strb = dst_we & dst_ready;
            stall    = |miss_idle;
         end else begin
            bus_out  = bus_hold;
            dst_strb = pending & dst_ready;
            stall    = (|miss_wait) && !at_limit;
            busy     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= IDLE;
         pending        <= '0;
         bus_hold       <= '0;
         wait_cnt       <= '0;
         xfer_count     <= '0;
         contention_err <= 1'b0;
         timeout_err    <= 1'b0;
      end else begin
         contention_err <= !err_clr && (contention_err || ((state == IDLE) && multi));
         timeout_err    <= !err_clr && (timeout_err || timed_out);
         if (cnt_inc && (xfer_count != CNT_MAX)) begin
            xfer_count <= xfer_count + CNT_W'(1);
         end
         case (state)
            IDLE: begin
               if (|miss_idle) begin
                  pending  <= miss_idle;
                  bus_hold <= mux_val;
                  wait_cnt <= '0;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               // Either every target has taken the data, or the timeout drops the rest.
               if (!(|miss_wait) || at_limit) begin
                  pending <= '0;
                  state   <= IDLE;
               end else begin
                  pending  <= miss_wait;
                  wait_cnt <= wait_cnt + WC_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sap_bus_fabric.sv
// Self-checking bench: transaction-level model compared every cycle, plus directed literal checks.
module tb_sap_bus_fabric;

   localparam int W  = 16;
   localparam int NS = 4;
   localparam int ND = 6;
   localparam int TO = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [NS-1:0]     src_oe;
   logic [NS*W-1:0]   src_data;
   logic [NS-1:0]     src_wide;
   logic [ND-1:0]     dst_we;
   logic [ND-1:0]     dst_ready;
   logic              err_clr;

   logic [W-1:0]      bus_out, s_bus_out;
   logic [ND-1:0]     dst_strb, s_dst_strb;
   logic              stall, busy, contention_err, timeout_err;
   logic              s_stall, s_busy, s_contention_err, s_timeout_err;
   logic [15:0]       xfer_count;
   logic [3:0]        s_xfer_count;

   sap_bus_fabric dut (
      .clk(clk), .rst(rst), .src_oe(src_oe), .src_data(src_data), .src_wide(src_wide),
      .dst_we(dst_we), .dst_ready(dst_ready), .err_clr(err_clr),
      .bus_out(bus_out), .dst_strb(dst_strb), .stall(stall), .busy(busy),
      .contention_err(contention_err), .timeout_err(timeout_err), .xfer_count(xfer_count)
   );

   sap_bus_fabric #(.CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .src_oe(src_oe), .src_data(src_data), .src_wide(src_wide),
      .dst_we(dst_we), .dst_ready(dst_ready), .err_clr(err_clr),
      .bus_out(s_bus_out), .dst_strb(s_dst_strb), .stall(s_stall), .busy(s_busy),
      .contention_err(s_contention_err), .timeout_err(s_timeout_err), .xfer_count(s_xfer_count)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: whether a transfer is outstanding, who still owes a write,
   // the latched value, how many WAIT cycles have elapsed, counts and flags.
   bit            m_wait   = 0;
   logic [ND-1:0] m_pend   = '0;
   logic [W-1:0]  m_hold   = '0;
   int            m_waited = 0;
   int            m_cnt    = 0;
   int            m_cnt4   = 0;
   bit            m_cont   = 0;
   bit            m_tmo    = 0;

   function automatic logic [W-1:0] ref_mux();
      logic [W-1:0] d;
      for (int i = 0; i < NS; i++) begin
         if (src_oe[i]) begin
            d = src_data[i*W +: W];
            return src_wide[i] ? d : (d & 16'h00FF);
         end
      end
      return '0;
   endfunction

   always @(negedge clk) begin
      logic [W-1:0]  e_bus;
      logic [ND-1:0] e_strb;
      logic [ND-1:0] left;
      bit            e_stall, e_busy, cset, tset;
      e_bus = '0; e_strb = '0; e_stall = 0; e_busy = 0;
      left = m_pend & ~dst_ready;
      if (rst === 1'b1) begin
         if (!m_wait) begin
            e_bus   = ref_mux();
            e_strb  = dst_we & dst_ready;
            e_stall = ((dst_we & ~dst_ready) != 0);
         end else begin
            e_bus   = m_hold;
            e_strb  = m_pend & dst_ready;
            e_stall = (left != 0) && (m_waited != TO - 1);
            e_busy  = 1;
         end
      end
      chk("bus_out", 32'(bus_out), 32'(e_bus));
      chk("dst_strb", 32'(dst_strb), 32'(e_strb));
      chk("stall", 32'(stall), 32'(e_stall));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("contention_err", 32'(contention_err), 32'(m_cont));
      chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
      chk("xfer_count", 32'(xfer_count), 32'(m_cnt));
      chk("xfer_count_w4", 32'(s_xfer_count), 32'(m_cnt4));

      if (rst !== 1'b1) begin
         m_wait = 0; m_pend = '0; m_hold = '0; m_waited = 0;
         m_cnt = 0; m_cnt4 = 0; m_cont = 0; m_tmo = 0;
      end else begin
         cset = !m_wait && ($countones(src_oe) > 1);
         tset = 0;
         if (!m_wait) begin
            if ((dst_we & ~dst_ready) != 0) begin
               m_wait = 1; m_pend = dst_we & ~dst_ready; m_hold = ref_mux(); m_waited = 0;
            end else if (dst_we != 0) begin
               if (m_cnt < 65535) m_cnt++;
               if (m_cnt4 < 15) m_cnt4++;
            end
         end else if (left == 0) begin
            m_wait = 0; m_pend = '0;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
         end else if (m_waited == TO - 1) begin
            m_wait = 0; m_pend = '0; tset = 1;
         end else begin
            m_pend = left; m_waited++;
         end
         m_cont = err_clr ? 0 : (m_cont | cset);
         m_tmo  = err_clr ? 0 : (m_tmo | tset);
      end
   end

   function automatic logic [NS*W-1:0] pack(input logic [W-1:0] d0, d1, d2, d3);
      return {d3, d2, d1, d0};
   endfunction

   task automatic drive(input logic r, input logic [NS-1:0] oe, input logic [NS*W-1:0] data,
                        input logic [NS-1:0] wide, input logic [ND-1:0] we,
                        input logic [ND-1:0] rdy, input logic clr);
      @(posedge clk);
      #1;
      rst = r; src_oe = oe; src_data = data; src_wide = wide;
      dst_we = we; dst_ready = rdy; err_clr = clr;
   endtask

   task automatic idle(input logic clr);
      drive(1'b1, '0, '0, '1, '0, '1, clr);
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   initial begin
      int stall_hi;
      logic [ND-1:0] strb_seen;
      rst = 1'b0; src_oe = '0; src_data = '0; src_wide = '0;
      dst_we = '0; dst_ready = '1; err_clr = 1'b0;

      // reset state
      sample();
      chk("reset_bus", 32'(bus_out), 32'h0);
      chk("reset_cnt", 32'(xfer_count), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      idle(0);

      // zero-wait transfer from a narrow source
      drive(1, 4'b0100, pack(16'h0, 16'h0, 16'hABCD, 16'h0), 4'b1011, 6'b000001, '1, 0);
      sample();
      chk("zw_bus", 32'(bus_out), 32'h00CD);
      chk("zw_strb", 32'(dst_strb), 32'h01);
      chk("zw_stall", 32'(stall), 32'h0);
      idle(0);
      sample();
      chk("zw_cnt", 32'(xfer_count), 32'h1);

      // contention, then clear, then clear beating a same-cycle set
      drive(1, 4'b0011, pack(16'h1234, 16'h5678, 16'h0, 16'h0), 4'b1111, '0, '1, 0);
      sample();
      chk("cont_bus", 32'(bus_out), 32'h1234);
      idle(0);
      sample();
      chk("cont_set", 32'(contention_err), 32'h1);
      idle(1);
      idle(0);
      sample();
      chk("cont_clr", 32'(contention_err), 32'h0);
      drive(1, 4'b0011, pack(16'h1234, 16'h5678, 16'h0, 16'h0), 4'b1111, '0, '1, 1);
      idle(0);
      sample();
      chk("cont_clr_prio", 32'(contention_err), 32'h0);

      // split wait
      drive(1, 4'b0001, pack(16'hBEEF, 16'h0, 16'h0, 16'h0), 4'b1111, 6'b000011, 6'b000001, 0);
      sample();
      chk("split_strb0", 32'(dst_strb), 32'h01);
      chk("split_stall0", 32'(stall), 32'h1);
      for (int c = 1; c < 3; c++) begin
         drive(1, 4'b0010, pack(16'h0, 16'h1111, 16'h0, 16'h0), 4'b1111, 6'b001000, 6'b000001, 0);
         sample();
         chk("split_hold", 32'(bus_out), 32'hBEEF);
         chk("split_stall", 32'(stall), 32'h1);
         chk("split_busy", 32'(busy), 32'h1);
      end
      drive(1, 4'b0010, pack(16'h0, 16'h1111, 16'h0, 16'h0), 4'b1111, '0, 6'b000011, 0);
      sample();
      chk("split_strb3", 32'(dst_strb), 32'h02);
      chk("split_stall3", 32'(stall), 32'h0);
      idle(0);
      sample();
      chk("split_cnt", 32'(xfer_count), 32'h2);
      chk("split_idle", 32'(busy), 32'h0);

      // timeout: nobody ever becomes ready
      stall_hi = 0; strb_seen = '0;
      drive(1, 4'b0001, pack(16'h7777, 16'h0, 16'h0, 16'h0), 4'b1111, 6'b000100, '0, 0);
      sample();
      stall_hi += int'(stall); strb_seen |= dst_strb;
      for (int c = 1; c < 16; c++) begin
         drive(1, '0, '0, '1, '0, '0, 0);
         sample();
         stall_hi += int'(stall); strb_seen |= dst_strb;
      end
      chk("to_stall_cycles", 32'(stall_hi), 32'd15);
      chk("to_last_stall", 32'(stall), 32'h0);
      chk("to_no_strb", 32'(strb_seen), 32'h0);
      idle(0);
      sample();
      chk("to_flag", 32'(timeout_err), 32'h1);
      chk("to_cnt", 32'(xfer_count), 32'h2);
      chk("to_idle", 32'(busy), 32'h0);
      idle(1);
      idle(0);
      sample();
      chk("to_clr", 32'(timeout_err), 32'h0);

      // reset in the middle of a wait
      drive(1, 4'b0001, pack(16'hAAAA, 16'h0, 16'h0, 16'h0), 4'b1111, 6'b000001, '0, 0);
      drive(1, '0, '0, '1, '0, '0, 0);
      sample();
      chk("mid_busy", 32'(busy), 32'h1);
      drive(0, '0, '0, '1, '0, '0, 0);
      sample();
      chk("mid_rst_bus", 32'(bus_out), 32'h0);
      chk("mid_rst_stall", 32'(stall), 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      idle(0);
      sample();
      chk("post_rst_cnt", 32'(xfer_count), 32'h0);
      chk("post_rst_busy", 32'(busy), 32'h0);
      drive(1, 4'b0001, pack(16'h0042, 16'h0, 16'h0, 16'h0), 4'b1111, 6'b000010, '1, 0);
      sample();
      chk("post_rst_strb", 32'(dst_strb), 32'h02);
      chk("post_rst_bus", 32'(bus_out), 32'h0042);
      idle(0);
      sample();
      chk("post_rst_cnt1", 32'(xfer_count), 32'h1);

      // saturation of the narrow counter
      for (int c = 0; c < 17; c++) begin
         drive(1, 4'b0001, pack(16'(c), 16'h0, 16'h0, 16'h0), 4'b1111, 6'b000001, '1, 0);
      end
      idle(0);
      sample();
      chk("sat_w4", 32'(s_xfer_count), 32'd15);
      chk("sat_w16", 32'(xfer_count), 32'd18);

      // randomized traffic in phases of varying readiness
      for (int c = 0; c < 3000; c++) begin
         logic [NS-1:0] oe;
         logic [ND-1:0] we, rdy;
         int phase;
         phase = (c / 500) % 3;
         oe  = ($urandom_range(0, 2) == 0) ? NS'($urandom) : NS'(1 << $urandom_range(0, NS - 1));
         we  = ($urandom_range(0, 3) == 0) ? '0 : ND'($urandom);
         if (phase == 0)      rdy = ND'($urandom) | ND'($urandom);
         else if (phase == 1) rdy = ND'($urandom) & ND'($urandom);
         else                 rdy = ($urandom_range(0, 7) == 0) ? ND'($urandom) : '0;
         drive(($urandom_range(0, 299) != 0), oe, {$urandom, $urandom}, NS'($urandom), we, rdy,
               ($urandom_range(0, 31) == 0));
      end
      idle(0);
      sample();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sap_bus_fabric.md
Name: sap_bus_fabric

Overview:
Parametrised shared-bus fabric for the SAP3 core family. It replaces the fixed priority-if bus mux with N_SRC drivers and N_DST write targets, mixed wide/narrow sources, per-destination ready handshakes with wait states, a stall output to the controller, contention and timeout error flags, and a transfer counter. It sits between the controller's control-word decode and the datapath units (reg file, memory, IR, ALU, I/O).

Parameters:
W, 16, full bus width
NARROW_W, 8, width of narrow sources; zero-extended to W
N_SRC, 4, number of bus drivers; index 0 has highest priority
N_DST, 6, number of write destinations
TIMEOUT, 15, maximum WAIT cycles before a transfer is abandoned (>=1)
CNT_W, 16, transfer counter width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
src_oe  in  N_SRC  output-enable request per source, from control word
src_data  in  N_SRC*W  source data; source i occupies bits [i*W +: W]
src_wide  in  N_SRC  1 = source drives full W; 0 = low NARROW_W bits, zero-extended
dst_we  in  N_DST  write request per destination, from control word
dst_ready  in  N_DST  destination can accept this cycle
err_clr  in  1  clears sticky error flags
bus_out  out  W  current bus value
dst_strb  out  N_DST  qualified write strobes
stall  out  1  controller must hold its microstep
busy  out  1  fabric is in WAIT
contention_err  out  1  sticky: more than one src_oe seen
timeout_err  out  1  sticky: WAIT reached TIMEOUT
xfer_count  out  CNT_W  number of completed transfers, saturating

Behaviour:
- Reset (rst==0 at posedge): state IDLE; pending, bus_hold, wait_cnt, xfer_count, and both error flags cleared. Outputs during reset: bus_out=0, dst_strb=0, stall=0, busy=0. Reset mid-WAIT abandons the transfer with no strobe.
- Source mux (combinational): the lowest set src_oe index wins. If no src_oe is set, the value is 0. A narrow source yields {0, data[NARROW_W-1:0]}.
- contention_err: set at posedge when popcount(src_oe)>1 in IDLE. It stays set until err_clr or reset. The lowest index still drives the bus.
- States: IDLE, WAIT.
- IDLE:
  - bus_out = mux value.
  - dst_strb = dst_we & dst_ready. Strobes fire in the same cycle; zero-wait latency.
  - If dst_we & ~dst_ready is nonzero:
    - stall=1 in that cycle.
    - At posedge: pending <= dst_we & ~dst_ready; bus_hold <= mux value; wait_cnt <= 0; go to WAIT.
  - Otherwise stall=0. If dst_we is nonzero, xfer_count increments at posedge.
- WAIT:
  - bus_out = bus_hold. src_oe and dst_we are ignored.
  - busy=1.
  - dst_strb = pending & dst_ready.
  - pending <= pending & ~dst_ready.
  - stall = |(pending & ~dst_ready).
  - When pending & ~dst_ready == 0: stall=0 in that cycle; next state IDLE; xfer_count increments.
  - Else if wait_cnt == TIMEOUT-1: timeout_err set; pending cleared; unserved writes dropped; stall=0 in that cycle; next state IDLE; no count increment.
  - Else wait_cnt increments.
- xfer_count saturates at all-ones.
- A transfer with dst_we==0 is not counted and never stalls.
- err_clr has priority over a same-cycle set: the flag reads 0 afterwards.

Decomposition:
- Package sap_bus_pkg:
  - state enum {IDLE, WAIT}
  - default W, NARROW_W, N_SRC, N_DST
  - localparam for the counter saturation value
- Sub-module sap_bus_src_mux: combinational priority select, zero-extension, and multi-driver detect. The top level holds the FSM, pending mask, hold register, counters, and flags.

Test Plan:
- Zero-wait transfer: src_oe=0100, src2 narrow data 0xABCD, dst_we=000001, all ready → bus_out=0x00CD, dst_strb=000001, stall=0, xfer_count 0→1.
- Contention: src_oe=0011, src0=0x1234 wide, src1=0x5678 wide → bus_out=0x1234 and contention_err=1 next cycle. err_clr pulse → 0.
- Split wait: dst_we=000011, dst_ready=000001 for 3 cycles, then 000011 → dst_strb[0] in cycle 0, dst_strb[1] in cycle 3. stall high cycles 0–2, low in cycle 3. bus_out holds the latched value throughout. xfer_count +1.
- Timeout: dst_we=000100, dst_ready=0 for ever, TIMEOUT=15 → stall high 15 cycles then low; timeout_err=1; no strobe; xfer_count unchanged; back to IDLE.
- Reset mid-WAIT: rst low during WAIT → next cycle bus_out=0, stall=0, busy=0, counters and flags 0. A later transfer behaves normally.
- Saturation: CNT_W=4, 17 zero-wait transfers → xfer_count=15.
